// File: rtl/adder_hold_pkg.sv
// Shared types and constants for the adder hold register and its BCD correction.
package adder_hold_pkg;

  typedef enum logic [1:0] {IDLE, ADJ, HOLD} state_e;
  typedef enum logic [1:0] {BIN, ADD, SUB} mode_e;

  localparam logic [3:0] BCD_ADJ     = 4'h6;
  localparam logic [3:0] BCD_SUB_ADJ = 4'hA;

  // Decimal add wins when both adjust requests are asserted.
  function automatic mode_e decode_mode(input logic daa_n, input logic dsa_n,
                                        input logic dec_en);
    mode_e m;
    m = BIN;
    if (dec_en) begin
      if (!daa_n)      m = ADD;
      else if (!dsa_n) m = SUB;
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Single-nibble decimal correction: +6 or -6 (mod 16), no carry out.
module bcd_nibble_adjust
  import adder_hold_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       enable,
  input  logic       subtract,
  output logic [3:0] adjusted
);

  logic [3:0] delta;

  assign delta    = subtract ? BCD_SUB_ADJ : BCD_ADJ;
  assign adjusted = enable ? (nibble + delta) : nibble;

endmodule

// File: rtl/adder_hold_unit.sv
// Adder hold register: captures the inverted ALU result and status, applies
// BCD correction in decimal mode, and presents result/flags under valid/ack.
//
//   state | meaning
//   IDLE  | nothing held, waiting for a capture
//   ADJ   | one-cycle decimal correction of the captured value
//   HOLD  | add and flags valid until ack
module adder_hold_unit
  import adder_hold_pkg::*;
#(
  parameter bit         DECIMAL_EN  = 1'b1,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk_2,
  input  logic       res_n,
  input  logic       capture,
  input  logic [7:0] result_n,
  input  logic       alu_cout_n,
  input  logic       half_carry,
  input  logic       overflow_n,
  input  logic       daa_n,
  input  logic       dsa_n,
  input  logic       ack,
  output logic [7:0] add,
  output logic       c_out,
  output logic       v_out,
  output logic       n_out,
  output logic       z_out,
  output logic       valid,
  output logic       busy,
  output logic       overrun
);

  state_e     state, state_nxt;
  mode_e      mode_q, mode_in;
  logic [7:0] raw_q, raw_in, add_q;
  logic       c_q, v_q, n_q, z_q, hc_q, overrun_q;
  logic       accept, drop;
  logic       en_lo, en_hi, sub_sel;
  logic [3:0] adj_lo, adj_hi;

  assign raw_in  = ~result_n;
  assign mode_in = decode_mode(daa_n, dsa_n, DECIMAL_EN);

  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    case (state)
      IDLE:    accept = capture;
      ADJ:     drop   = capture;
      HOLD: begin
        accept = capture & ack;
        drop   = capture & ~ack;
      end
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (mode_in == BIN) ? HOLD : ADJ;
      end
      ADJ:  state_nxt = HOLD;
      HOLD: begin
        if (accept)   state_nxt = (mode_in == BIN) ? HOLD : ADJ;
        else if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Correction direction: add adjusts on carry, subtract adjusts on borrow.
  assign sub_sel = (mode_q == SUB);
  assign en_lo   = ((mode_q == ADD) & hc_q) | ((mode_q == SUB) & ~hc_q);
  assign en_hi   = ((mode_q == ADD) & c_q)  | ((mode_q == SUB) & ~c_q);

  bcd_nibble_adjust u_adj_lo (
    .nibble   (raw_q[3:0]),
    .enable   (en_lo),
    .subtract (sub_sel),
    .adjusted (adj_lo)
  );

  bcd_nibble_adjust u_adj_hi (
    .nibble   (raw_q[7:4]),
    .enable   (en_hi),
    .subtract (sub_sel),
    .adjusted (adj_hi)
  );

  // N and Z come from the binary value, matching the original NMOS part.
  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) begin
      raw_q     <= 8'h00;
      add_q     <= RESET_VALUE;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      hc_q      <= 1'b0;
      mode_q    <= BIN;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        raw_q  <= raw_in;
        add_q  <= raw_in;
        c_q    <= ~alu_cout_n;
        v_q    <= ~overflow_n;
        hc_q   <= half_carry;
        n_q    <= raw_in[7];
        z_q    <= (raw_in == 8'h00);
        mode_q <= mode_in;
      end else if (state == ADJ) begin
        add_q <= {adj_hi, adj_lo};
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign add     = add_q;
  assign c_out   = c_q;
  assign v_out   = v_q;
  assign n_out   = n_q;
  assign z_out   = z_q;
  assign valid   = (state == HOLD);
  assign busy    = (state == ADJ) | ((state == HOLD) & ~ack);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_adder_hold_unit.sv
// Self-checking bench for adder_hold_unit: directed scenarios plus randomized
// transactions against an arithmetic BCD reference model.
module tb_adder_hold_unit;

  logic       clk_2 = 1'b0;
  logic       res_n = 1'b0;
  logic       capture = 1'b0;
  logic [7:0] result_n = 8'hFF;
  logic       alu_cout_n = 1'b1;
  logic       half_carry = 1'b0;
  logic       overflow_n = 1'b1;
  logic       daa_n = 1'b1;
  logic       dsa_n = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] add;
  logic       c_out, v_out, n_out, z_out, valid, busy, overrun;

  int checks = 0;
  int failures = 0;

  adder_hold_unit dut (
    .clk_2(clk_2), .res_n(res_n), .capture(capture), .result_n(result_n),
    .alu_cout_n(alu_cout_n), .half_carry(half_carry), .overflow_n(overflow_n),
    .daa_n(daa_n), .dsa_n(dsa_n), .ack(ack), .add(add), .c_out(c_out),
    .v_out(v_out), .n_out(n_out), .z_out(z_out), .valid(valid), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk_2 = ~clk_2;

  // Reference: decimal correction computed nibble by nibble with plain arithmetic.
  function automatic logic [7:0] ref_add(input logic [7:0] raw, input logic hc,
                                         input logic c, input int mode);
    int lo, hi;
    lo = raw % 16;
    hi = raw / 16;
    if (mode == 1) begin
      if (hc) lo = (lo + 6) % 16;
      if (c)  hi = (hi + 6) % 16;
    end else if (mode == 2) begin
      if (!hc) lo = (lo + 10) % 16;
      if (!c)  hi = (hi + 10) % 16;
    end
    return 8'((hi * 16) + lo);
  endfunction

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0; capture = 1'b0; ack = 1'b0;
    step(); step();
    res_n = 1'b1;
    step();
  endtask

  task automatic set_inputs(input logic [7:0] rn, input logic cn, input logic hc,
                            input logic on, input logic da, input logic ds);
    result_n = rn; alu_cout_n = cn; half_carry = hc; overflow_n = on;
    daa_n = da; dsa_n = ds;
  endtask

  task automatic capture_cycle();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  task automatic ack_cycle();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (add !== 8'h00) begin failures++; $display("FAIL reset_add got=%h exp=00", add); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {c_out, v_out, n_out, z_out}); end
    checks++; if ({valid, busy, overrun} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {valid, busy, overrun}); end
  endtask

  task automatic test_binary();
    set_inputs(8'hFC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    capture_cycle();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bin_valid got=%b exp=1", valid); end
    checks++; if (add !== 8'h03) begin failures++; $display("FAIL bin_add got=%h exp=03", add); end
    checks++; if ({c_out, v_out, n_out, z_out} !== 4'b0000) begin failures++; $display("FAIL bin_flags got=%b exp=0000", {c_out, v_out, n_out, z_out}); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if ({valid, busy, add} !== {2'b11, 8'h03}) begin failures++; $display("FAIL bin_hold cyc=%0d got=%b/%b/%h exp=1/1/03", i, valid, busy, add); end
    end
    ack = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bin_busy_ack got=%b exp=0", busy); end
    step(); ack = 1'b0;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bin_after_ack got=%b exp=0", valid); end
  endtask

  task automatic test_decimal_add();
    set_inputs(8'hE5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    capture_cycle();
    checks++; if ({busy, valid} !== 2'b10) begin failures++; $display("FAIL dadd_adj got=%b exp=10", {busy, valid}); end
    step();
    checks++; if ({valid, add} !== {1'b1, 8'h10}) begin failures++; $display("FAIL dadd_0901 got=%b/%h exp=1/10", valid, add); end
    checks++; if ({c_out, z_out, n_out} !== 3'b000) begin failures++; $display("FAIL dadd_0901_flags got=%b exp=000", {c_out, z_out, n_out}); end
    ack_cycle();
    set_inputs(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    capture_cycle(); step();
    checks++; if (add !== 8'h00) begin failures++; $display("FAIL dadd_9901 got=%h exp=00", add); end
    checks++; if ({c_out, n_out, z_out} !== 3'b110) begin failures++; $display("FAIL dadd_9901_flags got=%b exp=110", {c_out, n_out, z_out}); end
    ack_cycle();
  endtask

  task automatic test_decimal_sub();
    set_inputs(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    capture_cycle(); step();
    checks++; if ({valid, add, c_out} !== {1'b1, 8'h09, 1'b1}) begin failures++; $display("FAIL dsub_1001 got=%b/%h/%b exp=1/09/1", valid, add, c_out); end
    ack_cycle();
  endtask

  task automatic test_both_low();
    set_inputs(8'hE5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    capture_cycle(); step();
    checks++; if (add !== 8'h10) begin failures++; $display("FAIL both_low got=%h exp=10", add); end
    ack_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_inputs(8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    capture_cycle();
    set_inputs(8'hBD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    capture = 1'b1; ack = 1'b1;
    step();
    capture = 1'b0; ack = 1'b0;
    checks++; if ({valid, add, overrun} !== {1'b1, 8'h42, 1'b0}) begin failures++; $display("FAIL b2b got=%b/%h/%b exp=1/42/0", valid, add, overrun); end
    set_inputs(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    capture_cycle();
    checks++; if ({valid, add, c_out, overrun} !== {1'b1, 8'h42, 1'b0, 1'b1}) begin failures++; $display("FAIL hold_drop got=%b/%h/%b/%b exp=1/42/0/1", valid, add, c_out, overrun); end
    ack_cycle();
    do_reset();
    set_inputs(8'hE5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    capture_cycle();
    set_inputs(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    capture_cycle();
    checks++; if ({valid, add, overrun} !== {1'b1, 8'h10, 1'b1}) begin failures++; $display("FAIL adj_drop got=%b/%h/%b exp=1/10/1", valid, add, overrun); end
    ack_cycle();
  endtask

  task automatic test_reset_mid();
    set_inputs(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    capture_cycle();
    checks++; if (add !== 8'h3C) begin failures++; $display("FAIL pre_reset_add got=%h exp=3c", add); end
    #2 res_n = 1'b0;
    #1;
    checks++; if ({add, valid, busy, overrun} !== {8'h00, 3'b000}) begin failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=00/0/0/0", add, valid, busy, overrun); end
    step();
    res_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [7:0] rn, raw, exp_add;
    logic cn, hc, on, da, ds, exp_ovr;
    int mode, hold;
    do_reset();
    exp_ovr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rn = 8'($urandom); cn = 1'($urandom); hc = 1'($urandom); on = 1'($urandom);
      da = 1'($urandom); ds = 1'($urandom);
      raw = ~rn;
      mode = !da ? 1 : (!ds ? 2 : 0);
      exp_add = ref_add(raw, hc, !cn, mode);
      set_inputs(rn, cn, hc, on, da, ds);
      capture_cycle();
      if (mode != 0) begin
        checks++; if ({busy, valid} !== 2'b10) begin failures++; $display("FAIL rnd_adj t=%0d got=%b exp=10", t, {busy, valid}); end
        if ($urandom_range(0, 3) == 0) begin
          result_n = 8'($urandom); capture = 1'b1; exp_ovr = 1'b1;
        end
        step();
        capture = 1'b0;
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({valid, add, c_out, v_out, n_out, z_out, overrun} !==
            {1'b1, exp_add, !cn, !on, raw[7], raw == 8'h00, exp_ovr}) begin
          failures++;
          $display("FAIL rnd_hold t=%0d h=%0d got=%b/%h/%b%b%b%b/%b exp=1/%h/%b%b%b%b/%b",
                   t, h, valid, add, c_out, v_out, n_out, z_out, overrun,
                   exp_add, !cn, !on, raw[7], raw == 8'h00, exp_ovr);
        end
        if (h < hold) begin
          if ($urandom_range(0, 4) == 0) begin
            result_n = 8'($urandom); capture = 1'b1; exp_ovr = 1'b1;
          end
          step();
          capture = 1'b0;
        end
      end
      ack_cycle();
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rnd_ack t=%0d got=%b exp=0", t, valid); end
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_decimal_add();
    test_decimal_sub();
    test_both_low();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_hold_unit.md
Name: adder_hold_unit

Overview:
Consumer of the ALU's inverted result. It captures result_n and the ALU status outputs on a capture strobe and restores true polarity. In decimal mode it applies the nibble-wise BCD correction that the ALU does not perform. It then holds the result and flags for the bus/flag logic under a valid/ack handshake. It sits between the ALU and the internal data/special buses and stands in for the adder hold register.

Parameters:
DECIMAL_EN, 1, 1 = honour daa_n/dsa_n; 0 = decimal inputs ignored, every capture is binary
RESET_VALUE, 8'h00, value of add after reset

Ports:
clk_2  input  1  phase-2 clock; all state updates on rising edge
res_n  input  1  asynchronous active-low reset
capture  input  1  ALU outputs are valid this cycle; request capture
result_n  input  8  inverted ALU result
alu_cout_n  input  1  ALU carry out, active low (includes decimal carry)
half_carry  input  1  carry from bit 3 to 4, active high (includes decimal half carry)
overflow_n  input  1  ALU overflow, active low
daa_n  input  1  decimal add adjust request, active low
dsa_n  input  1  decimal subtract adjust request, active low
ack  input  1  consumer has taken add/flags
add  output  8  held, true-polarity, adjusted result
c_out  output  1  held carry
v_out  output  1  held overflow
n_out  output  1  held negative
z_out  output  1  held zero
valid  output  1  add/flags are stable and valid
busy  output  1  capture cannot be accepted this cycle
overrun  output  1  sticky: a capture was dropped

Behaviour:
- Reset (res_n low, asynchronous): state IDLE, add=RESET_VALUE, c/v/n/z=0, valid=0, busy=0, overrun=0. This takes effect immediately, mid-operation included.
- States: IDLE, ADJ, HOLD.
- Capture register update:
  - raw <= ~result_n
  - c <= ~alu_cout_n
  - v <= ~overflow_n
  - hc <= half_carry
  - n <= raw[7] and z <= (raw==0), both taken from the binary (pre-adjust) value, matching NMOS behaviour
  - mode latched: ADD if daa_n=0 (priority when both are low), SUB if dsa_n=0 only, else BIN. DECIMAL_EN=0 forces BIN.
- IDLE: on capture -> perform capture update. Go to ADJ if mode != BIN, else go to HOLD with add=raw.
- ADJ (one cycle, busy=1, valid=0): add <= adjusted raw, then go to HOLD.
  - ADD: low nibble +6 if hc=1; high nibble +6 if c=1.
  - SUB: low nibble -6 if hc=0; high nibble -6 if c=0.
  - Each nibble is computed mod 16. There is no carry or borrow between nibbles and no change to c.
- HOLD: valid=1. Outputs are stable until ack.
  - ack without capture -> IDLE, valid=0 next cycle.
  - ack with capture in the same cycle -> new capture accepted; next state is ADJ or HOLD as from IDLE. Old values are replaced at that edge.
  - capture without ack -> capture dropped, overrun<=1, held values unchanged.
- busy = (state==ADJ) or (state==HOLD and ack==0).
- A capture during ADJ is dropped and sets overrun.
- overrun clears only on reset.
- Latency, capture edge k: binary valid at k+1; decimal valid at k+2.
- ack in IDLE or ADJ is ignored.

Decomposition:
- Shared package adder_hold_pkg:
  - state enum {IDLE, ADJ, HOLD}
  - mode enum {BIN, ADD, SUB}
  - constants BCD_ADJ=4'h6 and BCD_SUB_ADJ=4'hA (-6 mod 16)
- One sub-module, bcd_nibble_adjust: combinational. Inputs are a 4-bit nibble, enable and subtract; output is the 4-bit adjusted nibble. It is instantiated twice (low and high nibble).

Test Plan:
- Reset mid-operation: res_n low while in HOLD with add=0x3C -> add=0x00, valid=0, busy=0, overrun=0 with no clock edge required.
- Binary: result_n=0xFC, alu_cout_n=1, overflow_n=1, daa_n=dsa_n=1, capture 1 cycle -> next cycle valid=1, add=0x03, c=v=n=z=0. Values are held for 5 cycles without ack; ack -> valid=0.
- Decimal add 09+01:
  - Stimulus: result_n=0xE5 (raw 0x1A), half_carry=1, alu_cout_n=1, daa_n=0.
  - Cycle 1: busy=1, valid=0.
  - Cycle 2: add=0x10, c=0, z=0, n=0.
- Decimal add 99+01: result_n=0x55 (raw 0xAA), half_carry=1, alu_cout_n=0, daa_n=0 -> add=0x00, c=1, n=1, z=0 (flags from binary).
- Decimal subtract 10-01: result_n=0xF0 (raw 0x0F), half_carry=0, alu_cout_n=0, dsa_n=0 -> add=0x09, c=1.
- Handshake edges:
  - In HOLD, ack+capture in the same cycle with raw 0x42 (BIN) -> valid stays 1 and add=0x42 next cycle.
  - A capture during ADJ, or in HOLD without ack, leaves add unchanged and sets overrun=1.
  - daa_n=dsa_n=0 selects the ADD adjustment.
